// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, round K ROM and schedule FSM encoding
package sha256_pkg;

    localparam int SHA256_WORDS  = 16;
    localparam int SHA256_ROUNDS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GEN  = 2'd2
    } state_e;

    localparam logic [31:0] K [SHA256_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha_small_sigma.sv
// sha_small_sigma: SHA-256 small sigma functions s0 and s1 of one word
module sha_small_sigma (
    input  logic [31:0] x,
    output logic [31:0] s0,
    output logic [31:0] s1
);

    assign s0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    assign s1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);

endmodule

// File: rtl/sha_msg_sched.sv
// sha_msg_sched: SHA-256 message schedule, 16-word sliding window; SHA_SCHED_KADD_EN adds K[t] to out0
module sha_msg_sched
    import sha256_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0,
    output logic [5:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    if (DATA_W != 32) begin : g_bad_width
        $error("sha_msg_sched supports DATA_W == 32 only");
    end

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [5:0]        t_q;
    logic              done_q;
    logic [DATA_W-1:0] w_q [SHA256_WORDS];
    logic [DATA_W-1:0] w_d [SHA256_WORDS];
    logic [31:0]       s0_w1, s1_w14, s1_unused, s0_unused;
    logic [31:0]       w_new;
    logic              load_hs, gen_hs;

    sha_small_sigma u_sig_lo (.x(w_q[1]),  .s0(s0_w1),     .s1(s1_unused));
    sha_small_sigma u_sig_hi (.x(w_q[14]), .s0(s0_unused), .s1(s1_w14));

    assign load_hs = (state_q == LOAD) && in_valid;
    assign gen_hs  = (state_q == GEN) && out_ready;
    assign w_new   = s1_w14 + w_q[9] + s0_w1 + w_q[0];

    // window shifts toward w[0] on every handshake; w[15] takes the input word or the new schedule word
    always_comb begin
        for (int i = 0; i < SHA256_WORDS - 1; i++) w_d[i] = (load_hs || gen_hs) ? w_q[i+1] : w_q[i];
        w_d[SHA256_WORDS-1] = load_hs ? in0 : gen_hs ? w_new : w_q[SHA256_WORDS-1];
    end

    // control FSM, counters, window and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
            w_q     <= '{default: '0};
        end else begin
            w_q    <= w_d;
            done_q <= gen_hs && (t_q == 6'(ROUNDS - 1));
            case (state_q)
                IDLE: if (run) begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                    t_q     <= '0;
                end
                LOAD: if (in_valid) begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(SHA256_WORDS - 1)) state_q <= GEN;
                end
                GEN: if (out_ready) begin
                    t_q <= t_q + 6'd1;
                    if (t_q == 6'(ROUNDS - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == LOAD;
    assign out_valid = state_q == GEN;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign out_idx   = t_q;
`ifdef SHA_SCHED_KADD_EN
    assign out0 = out_valid ? w_q[0] + K[t_q] : '0;
`else
    assign out0 = out_valid ? w_q[0] : '0;
`endif

endmodule

// File: tb/tb_sha_msg_sched.sv
// tb_sha_msg_sched: randomized bench for sha_msg_sched against a schedule-array reference model
module tb_sha_msg_sched;
`ifdef SHA_SCHED_KADD_EN
    import sha256_pkg::*;
`endif

    logic        clk = 1'b0, rst = 1'b1, run = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in0 = '0;
    logic        in_ready, out_valid, busy, done;
    logic [31:0] out0;
    logic [5:0]  out_idx;

    sha_msg_sched dut (
        .clk(clk), .rst(rst), .run(run), .in0(in0), .in_valid(in_valid), .in_ready(in_ready),
        .out0(out0), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] kadd(input int i);
`ifdef SHA_SCHED_KADD_EN
        return K[i];
`else
        return (i < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    // reference model: whole-block schedule array built from the textbook recurrence
    logic [31:0] msg [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    int          ph = 0, mcnt = 0, mt = 0, done_cnt = 0;
    bit          done_next = 1'b0, check_en = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [31:0] p0 = '0;
    logic [5:0]  pi = '0;

    task automatic build_sched();
        for (int i = 0; i < 16; i++) exp_w[i] = msg[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = sig1(exp_w[i-2]) + exp_w[i-7] + sig0(exp_w[i-15]) + exp_w[i-16];
    endtask

    // single compare process: checks every output each cycle, then advances the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, ph == 1});
            chk("out_valid", {31'b0, out_valid}, {31'b0, ph == 2});
            chk("busy", {31'b0, busy}, {31'b0, ph != 0});
            chk("done", {31'b0, done}, {31'b0, done_next});
            if (done) done_cnt++;
            if (ph == 2) begin
                chk("out_idx", {26'b0, out_idx}, mt);
                chk("out0", out0, exp_w[mt] + kadd(mt));
                got_w[mt] = out0;
                if (pv && !pr) begin
                    chk("stall_out0", out0, p0);
                    chk("stall_idx", {26'b0, out_idx}, {26'b0, pi});
                end
            end
        end
        pv = (ph == 2) && !rst;
        pr = out_ready;
        p0 = out0;
        pi = out_idx;
        done_next = 1'b0;
        if (rst) ph = 0;
        else case (ph)
            0: if (run) begin ph = 1; mcnt = 0; end
            1: if (in_valid) begin
                msg[mcnt] = in0;
                mcnt++;
                if (mcnt == 16) begin build_sched(); ph = 2; mt = 0; end
            end
            2: if (out_ready) begin
                mt++;
                if (mt == 64) begin ph = 0; done_next = 1'b1; end
            end
            default: ph = 0;
        endcase
    end

    int stall_pct = 0;
    always @(posedge clk) begin
        #1;
        out_ready = ($urandom_range(99) >= stall_pct);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'h0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        chk({tag, "_out0"}, out0, 32'h0);
        chk({tag, "_out_idx"}, {26'b0, out_idx}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_done"}, {31'b0, done}, 32'h0);
    endtask

    // pulses run (with junk on in0/in_valid that IDLE must ignore) then feeds 16 words with random gaps
    task automatic load_block(input logic [31:0] m[16], input int gap_pct);
        int  k, guard;
        bit  v, acc;
        k = 0;
        guard = 0;
        run = 1'b1;
        in_valid = 1'b1;
        in0 = $urandom();
        tick();
        run = 1'b0;
        while (k < 16 && guard < 500) begin
            v = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in0 = v ? m[k] : $urandom();
            acc = v && in_ready;
            tick();
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        if (k < 16) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: accepted %0d words, required 16", k);
        end
    endtask

    // waits for done with a cycle bound, optionally pulsing run and junk inputs during GEN
    task automatic wait_done(input bit noise);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            run = noise && out_valid && (out_idx < 60) && ($urandom_range(3) == 0);
            in_valid = noise && ($urandom_range(1) == 0);
            in0 = $urandom();
            tick();
            n++;
        end
        run = 1'b0;
        in_valid = 1'b0;
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 3000 cycles");
        end
    endtask

    logic [31:0] abc [16];
    logic [31:0] rnd [16];

    initial begin
        int n;
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) rnd[i] = $urandom();

        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        check_en = 1'b1;
        repeat (2) tick();

        // abc block at full rate
        stall_pct = 0;
        load_block(abc, 0);
        wait_done(1'b0);
        tick();
        tick();
        chk("abc_done_once", done_cnt, 1);
        chk("abc_w0", got_w[0], 32'h61626380 + kadd(0));
`ifdef SHA_SCHED_KADD_EN
        chk("abc_kadd_t0", got_w[0], 32'hA3EC9318);
`endif
        chk("abc_w16", got_w[16], 32'h61626380 + kadd(16));
        chk("abc_w17", got_w[17], 32'h000F0000 + kadd(17));
        chk("abc_w18", got_w[18], 32'h7DA86405 + kadd(18));
        chk("abc_w19", got_w[19], 32'h600003C6 + kadd(19));
        chk("abc_w63", got_w[63], 32'h12B1EDEB + kadd(63));
        chk("model_w63", exp_w[63], 32'h12B1EDEB);

        // abc under backpressure with run/in_valid noise, then a run in the done cycle with a gappy random block
        stall_pct = 50;
        repeat (3) begin
            in_valid = 1'b1;
            in0 = $urandom();
            tick();
        end
        in_valid = 1'b0;
        load_block(abc, 0);
        wait_done(1'b1);
        load_block(rnd, 40);
        wait_done(1'b1);
        stall_pct = 0;
        tick();
        tick();
        chk("rand_done_count", done_cnt, 3);

        // reset in the middle of GEN at t=30, then a clean abc block
        stall_pct = 30;
        load_block(abc, 0);
        n = 0;
        while (!(out_valid && out_idx == 6'd30) && n < 500) begin
            tick();
            n++;
        end
        chk("reach_t30", {31'b0, n < 500}, 32'h1);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        repeat (3) tick();
        chk("midrst_no_done", done_cnt, 3);
        stall_pct = 0;
        load_block(abc, 0);
        wait_done(1'b0);
        tick();
        tick();
        chk("final_w63", got_w[63], 32'h12B1EDEB + kadd(63));
        chk("final_done_count", done_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
